// File: rtl/bus_resp_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_resp_regfile_pkg
// Purpose  : Shared definitions for the bus responder register file: FSM
//            state encodings, default bus widths and a helper that sizes the
//            register-bank index.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package bus_resp_regfile_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    // Index width for a bank of 'depth' entries; never narrower than 1 bit.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_resp_regbank.sv
`default_nettype none
// ============================================================================
// Module   : bus_resp_regbank
// Purpose  : DEPTH x DATA_W register storage with synchronous write and a
//            registered read port. Whole bank clears on rst.
// Ports    : clk, rst      - clock, asynchronous active-high reset
//            we_i, re_i    - write / read enables (mutually exclusive)
//            idx_i         - register index (caller guarantees < DEPTH)
//            wdata_i       - write data
//            rdata_o       - registered read data, holds until next read
// Revision : 1.0 - initial release
// ============================================================================
module bus_resp_regbank
    import bus_resp_regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 8,
    parameter int IDX_W  = idx_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            if (we_i) begin
                mem_q[idx_i] <= wdata_i;
            end
            if (re_i) begin
                rdata_q <= mem_q[idx_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/bus_resp_regfile.sv
`default_nettype none
// ============================================================================
// Module   : bus_resp_regfile
// Purpose  : Bus target behind one hsel line. Accepts one read/write when
//            hsel and req are both high in IDLE, waits WAIT_STATES cycles,
//            performs a single-cycle register access and returns a one-cycle
//            ready pulse with read data or an out-of-range error flag.
// Ports    : clk, rst      - clock, asynchronous active-high reset
//            hsel_i        - target select from the initiator's decoder
//            req_i         - request strobe (sampled only in IDLE)
//            wr_i          - 1 = write, 0 = read (sampled with req)
//            addr_i        - register index (sampled with req)
//            wdata_i       - write data (sampled with req)
//            rdata_o       - registered read data
//            ready_o       - single-cycle completion pulse
//            err_o         - out-of-range flag, valid only with ready_o
//            busy_o        - high from acceptance until ready
// Revision : 1.0 - initial release
// ============================================================================
module bus_resp_regfile
    import bus_resp_regfile_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DEPTH       = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hsel_i,
    input  logic              req_i,
    input  logic              wr_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              ready_o,
    output logic              err_o,
    output logic              busy_o
);

    localparam int IDX_W = idx_width(DEPTH);
    localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
    // One extra bit so DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic              wr_q,    wr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              busy_q,  busy_d;
    logic              ready_q, ready_d;
    logic              err_q,   err_d;

    logic in_range;
    logic bank_we;
    logic bank_re;

    assign in_range = ({1'b0, addr_q} < DEPTH_LIM);
    assign bank_we  = (state_q == ST_ACCESS) &&  wr_q && in_range;
    assign bank_re  = (state_q == ST_ACCESS) && !wr_q && in_range;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        busy_d  = busy_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (hsel_i && req_i) begin
                    addr_d  = addr_i;
                    wr_d    = wr_i;
                    wdata_d = wdata_i;
                    busy_d  = 1'b1;
                    cnt_d   = CNT_LOAD;
                    state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_ACCESS;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_ACCESS: begin
                // Completion is registered here so ready/err appear in RESP,
                // and busy drops on the very same edge.
                ready_d = 1'b1;
                err_d   = !in_range;
                busy_d  = 1'b0;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    bus_resp_regbank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .we_i    (bank_we),
        .re_i    (bank_re),
        .idx_i   (addr_q[IDX_W-1:0]),
        .wdata_i (wdata_q),
        .rdata_o (rdata_o)
    );

    assign ready_o = ready_q;
    assign err_o   = err_q;
    assign busy_o  = busy_q;

endmodule
`default_nettype wire
